// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver types and constants.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam int FRAME_LEN = 11;
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: synchronizes ps2_clk/ps2_data, deglitches the clock and emits a falling-edge strobe.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] clk_s, data_s;
    logic [FW-1:0] cnt;
    logic filt, sclk, flip;
    assign sclk = clk_s[SYNC_STAGES-1];
    assign data = data_s[SYNC_STAGES-1];
    // the FILTER_LEN-th consecutive differing sample flips the filtered level
    assign flip = (sclk != filt) && (cnt == FW'(FILTER_LEN - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s <= '1;
            data_s <= '1;
            filt <= 1'b1;
            cnt <= '0;
            fall <= 1'b0;
        end else begin
            clk_s <= SYNC_STAGES'({clk_s, ps2_clk});
            data_s <= SYNC_STAGES'({data_s, ps2_data});
            filt <= flip ? ~filt : filt;
            cnt <= (sclk == filt || flip) ? '0 : cnt + 1'b1;
            fall <= flip & filt;
        end
    end
endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 device-to-host receiver feeding a 32-bit scancode history.
// Optional frame timeout enabled with PS2_TIMEOUT_EN.
module ps2_keycode_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        key_valid,
    output logic        parity_err,
    output logic        frame_err
);
    import ps2_pkg::*;
    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic par, par_n;
    logic [31:0] kc_n;
    logic kv_n, pe_n, fe_n;
    logic fall, data;
    ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sf (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .fall(fall), .data(data)
    );
`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt, to_n;
    always_ff @(posedge clk) to_cnt <= rst ? '0 : to_n;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            par <= 1'b0;
            keycode <= '0;
            key_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sh <= sh_n;
            par <= par_n;
            keycode <= kc_n;
            key_valid <= kv_n;
            parity_err <= pe_n;
            frame_err <= fe_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sh_n = sh;
        par_n = par;
        kc_n = keycode;
        kv_n = 1'b0;
        pe_n = 1'b0;
        fe_n = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    state_n = data ? IDLE : DATA;
                    cnt_n = '0;
                end
                DATA: begin
                    sh_n = {data, sh[7:1]};
                    cnt_n = cnt + 3'd1;
                    state_n = (cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n = data;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    kv_n = data && (^{sh, par});
                    fe_n = !data;
                    pe_n = data && !(^{sh, par});
                    kc_n = kv_n ? {keycode[23:0], sh} : keycode;
                end
                default: state_n = IDLE;
            endcase
        end
`ifdef PS2_TIMEOUT_EN
        to_n = (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
        // timeout overrides any strobe landing on the same cycle
        if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
            state_n = IDLE;
            cnt_n = '0;
            sh_n = sh;
            par_n = par;
            kc_n = keycode;
            kv_n = 1'b0;
            pe_n = 1'b0;
            fe_n = 1'b1;
            to_n = '0;
        end
`endif
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: scoreboard bench for ps2_keycode_rx with directed PS/2 frames.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;
    localparam int H = 500;
    localparam int TO_CYC = 2000;
    typedef struct {
        int kind;
        logic [31:0] kc;
    } ev_t;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [31:0] keycode;
    logic key_valid, parity_err, frame_err;
    ev_t q[$];
    logic [31:0] exp_kc = '0;
    int tests = 0, fails = 0;

    ps2_keycode_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_key(input logic [7:0] b);
        exp_kc = {exp_kc[23:0], b};
        q.push_back('{0, exp_kc});
    endtask

    task automatic exp_err(input int kind);
        q.push_back('{kind, exp_kc});
    endtask

    task automatic send(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            #(H / 2);
            ps2_clk = 1'b0;
            #H;
            ps2_clk = 1'b1;
            #(H / 2);
        end
        ps2_data = 1'b1;
        #2000;
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_kc = '0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (key_valid || parity_err || frame_err)) begin
            int kind;
            ev_t e;
            kind = key_valid ? 0 : (parity_err ? 1 : 2);
            tests++;
            if ($countones({key_valid, parity_err, frame_err}) != 1) begin
                fails++;
                $display("FAIL pulse_excl: got kv=%b pe=%b fe=%b required one-hot", key_valid, parity_err, frame_err);
            end else if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got kind %0d keycode %h required none", kind, keycode);
            end else begin
                e = q.pop_front();
                if (e.kind != kind || keycode !== e.kc) begin
                    fails++;
                    $display("FAIL event: got kind %0d keycode %h required kind %0d keycode %h", kind, keycode, e.kind, e.kc);
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_keycode", keycode, 32'h0);
        chk("reset_flags", {29'd0, key_valid, parity_err, frame_err}, 32'h0);
        exp_key(8'h16);
        send(8'h16, 1'b0, 1'b1, FRAME_LEN);
        chk("single_16", keycode, 32'h0000_0016);
        chk("pending_1", q.size(), 0);

        do_reset();
        chk("reset2_keycode", keycode, 32'h0);
        exp_key(8'h16);
        send(8'h16, 1'b0, 1'b1, FRAME_LEN);
        exp_key(PS2_BREAK);
        send(PS2_BREAK, 1'b0, 1'b1, FRAME_LEN);
        exp_key(8'h16);
        send(8'h16, 1'b0, 1'b1, FRAME_LEN);
        chk("break_seq", keycode, 32'h0016_F016);

        exp_err(1);
        send(8'h1C, 1'b1, 1'b1, FRAME_LEN);
        chk("parity_hold", keycode, 32'h0016_F016);

        exp_err(2);
        send(8'h2E, 1'b0, 1'b0, FRAME_LEN);
        chk("stop_hold", keycode, 32'h0016_F016);
        exp_key(8'h2E);
        send(8'h2E, 1'b0, 1'b1, FRAME_LEN);
        chk("after_stop_err", keycode, 32'h16F0_162E);
        chk("pending_2", q.size(), 0);

        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #300 ps2_clk = 1'b0;
            #50 ps2_clk = 1'b1;
        end
        #300 ps2_data = 1'b1;
        #1000;
        exp_key(8'h3A);
        send(8'h3A, 1'b0, 1'b1, FRAME_LEN);
        chk("glitch_immune", keycode, 32'hF016_2E3A);

        send(8'h45, 1'b0, 1'b1, 5);
        do_reset();
        chk("midframe_reset", keycode, 32'h0);
        exp_key(8'h45);
        send(8'h45, 1'b0, 1'b1, FRAME_LEN);
        chk("after_reset_45", keycode, 32'h0000_0045);

`ifdef PS2_TIMEOUT_EN
        exp_err(2);
        send(8'h77, 1'b0, 1'b1, 5);
        #(21 * TO_CYC);
        exp_key(8'h15);
        send(8'h15, 1'b0, 1'b1, FRAME_LEN);
        chk("timeout_recover", {24'd0, keycode[7:0]}, 32'h15);
`endif
        chk("pending_end", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
